immediate_extender: RTL and testbench

IMMEDIATE_EXTENDER -- requirements
Module: immediate_extender

---
 rtl/immediate_extender.sv | 84 ++++++++
 tb/tb_immediate_extender.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/immediate_extender.sv
// immediate_extender: RV32I immediate decode (I/S/B/U/J) with a sticky
// unsupported-select flag.
// Optional build macro IMM_EXT_REG_EN registers Imm_Ext (1-cycle latency);
// without it Imm_Ext is purely combinational.
module immediate_extender #(
  parameter logic [31:0] DEFAULT_IMM = 32'h0000_0000
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic [31:0] Instr,
  input  logic [2:0]  Imm_Type_Sel,
  output logic [31:0] Imm_Ext,
  output logic        Imm_Sel_Err
);

  localparam int unsigned XLEN  = 32;
  localparam int unsigned SEL_W = 3;

  localparam logic [SEL_W-1:0] IMM_I = SEL_W'(0);
  localparam logic [SEL_W-1:0] IMM_S = SEL_W'(1);
  localparam logic [SEL_W-1:0] IMM_B = SEL_W'(2);
  localparam logic [SEL_W-1:0] IMM_U = SEL_W'(3);
  localparam logic [SEL_W-1:0] IMM_J = SEL_W'(4);

  logic [XLEN-1:0] imm_c;
  logic            sel_bad_c;
  logic            sel_err_d;
  logic            sel_err_q;

  // Opcode field never feeds any immediate format.
  logic unused_opcode;
  assign unused_opcode = ^Instr[6:0];

  // Format decode: sign bit is always Instr[31] except for U, which fills bit 31 directly.
  always_comb begin
    imm_c     = DEFAULT_IMM;
    sel_bad_c = 1'b0;
    case (Imm_Type_Sel)
      IMM_I:   imm_c = {{21{Instr[31]}}, Instr[30:20]};
      IMM_S:   imm_c = {{21{Instr[31]}}, Instr[30:25], Instr[11:7]};
      IMM_B:   imm_c = {{20{Instr[31]}}, Instr[7], Instr[30:25], Instr[11:8], 1'b0};
      IMM_U:   imm_c = {Instr[31:12], 12'b0};
      IMM_J:   imm_c = {{12{Instr[31]}}, Instr[19:12], Instr[20], Instr[30:21], 1'b0};
      default: begin
        imm_c     = DEFAULT_IMM;
        sel_bad_c = 1'b1;
      end
    endcase
  end

  // Sticky error: once an unsupported select is seen it holds until reset.
  always_comb begin
    sel_err_d = sel_err_q | sel_bad_c;
  end

  // Error flag register; reset wins over a simultaneous set.
  always_ff @(posedge CLK) begin
    if (RST) sel_err_q <= 1'b0;
    else     sel_err_q <= sel_err_d;
  end

  assign Imm_Sel_Err = sel_err_q;

`ifdef IMM_EXT_REG_EN
  logic [XLEN-1:0] imm_ext_d;
  logic [XLEN-1:0] imm_ext_q;

  // Next registered immediate is the current decode.
  always_comb begin
    imm_ext_d = imm_c;
  end

  // Output register for the immediate; cleared by reset.
  always_ff @(posedge CLK) begin
    if (RST) imm_ext_q <= '0;
    else     imm_ext_q <= imm_ext_d;
  end

  assign Imm_Ext = imm_ext_q;
`else
  assign Imm_Ext = imm_c;
`endif

endmodule

// File: tb/tb_immediate_extender.sv
// Self-checking bench for immediate_extender; covers both builds (IMM_EXT_REG_EN).
module tb_immediate_extender;

  localparam logic [31:0] DEF_IMM = 32'hDEAD_BEEF;

  logic        CLK = 1'b0;
  logic        RST = 1'b0;
  logic [31:0] Instr = 32'h0;
  logic [2:0]  Imm_Type_Sel = 3'd0;
  logic [31:0] Imm_Ext;
  logic        Imm_Sel_Err;

  int vectors = 0;
  int miscompares = 0;

  immediate_extender #(.DEFAULT_IMM(DEF_IMM)) dut (
    .CLK(CLK),
    .RST(RST),
    .Instr(Instr),
    .Imm_Type_Sel(Imm_Type_Sel),
    .Imm_Ext(Imm_Ext),
    .Imm_Sel_Err(Imm_Sel_Err)
  );

  always #5 CLK = ~CLK;

  // Reference: field placement done with arithmetic shifts on a signed word.
  function automatic logic [31:0] ref_imm(input logic [31:0] ins, input logic [2:0] sel);
    logic signed [31:0] s;
    logic [12:0] b13;
    logic [20:0] j21;
    case (sel)
      3'd0: begin s = ins; s = s >>> 20; ref_imm = s; end
      3'd1: begin s = ins; s = s >>> 20; ref_imm = (s & ~32'h1F) | {27'b0, ins[11:7]}; end
      3'd2: begin
        b13 = {ins[31], ins[7], ins[30:25], ins[11:8], 1'b0};
        s = {b13, 19'b0}; s = s >>> 19; ref_imm = s;
      end
      3'd3: ref_imm = ins & 32'hFFFF_F000;
      3'd4: begin
        j21 = {ins[31], ins[19:12], ins[20], ins[30:21], 1'b0};
        s = {j21, 11'b0}; s = s >>> 11; ref_imm = s;
      end
      default: ref_imm = DEF_IMM;
    endcase
  endfunction

  // Apply inputs away from the active edge.
  task automatic drive(input logic [31:0] ins, input logic [2:0] sel);
    @(negedge CLK);
    Instr = ins;
    Imm_Type_Sel = sel;
  endtask

  // Wait until Imm_Ext reflects the driven inputs.
  task automatic settle();
`ifdef IMM_EXT_REG_EN
    @(posedge CLK); #1;
`else
    #1;
`endif
  endtask

  task automatic test_reset();
    logic [31:0] ins;
    ins = $urandom | 32'h8000_0000;
    drive(ins, 3'd3);
    RST = 1'b1;
    @(posedge CLK); #1;
    vectors++;
    if (Imm_Sel_Err !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_err: got %b want 0", Imm_Sel_Err);
    end
`ifdef IMM_EXT_REG_EN
    vectors++;
    if (Imm_Ext !== 32'h0) begin
      miscompares++;
      $display("FAIL reset_imm: got %h want 00000000", Imm_Ext);
    end
`else
    vectors++;
    if (Imm_Ext !== ref_imm(ins, 3'd3)) begin
      miscompares++;
      $display("FAIL reset_comb_imm: got %h want %h", Imm_Ext, ref_imm(ins, 3'd3));
    end
`endif
    @(negedge CLK);
    RST = 1'b0;
  endtask

  task automatic test_directed();
    logic [31:0] ins_t [8];
    logic [2:0]  sel_t [8];
    logic [31:0] exp_t [8];
    ins_t = '{32'h2A2A_2A2A, 32'h2A2A_2A2A, 32'h2A2A_2A2A, 32'h2A2A_2A2A,
              32'h2A2A_2A2A, 32'h8000_0000, 32'h8000_0000, 32'h8000_0000};
    sel_t = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd0, 3'd2, 3'd4};
    exp_t = '{32'h0000_02A2, 32'h0000_02B4, 32'h0000_02B4, 32'h2A2A_2000,
              32'h000A_22A2, 32'hFFFF_F800, 32'hFFFF_F000, 32'hFFF0_0000};
    for (int i = 0; i < 8; i++) begin
      drive(ins_t[i], sel_t[i]);
      settle();
      vectors++;
      if (Imm_Ext !== exp_t[i]) begin
        miscompares++;
        $display("FAIL directed[%0d] sel=%0d instr=%h: got %h want %h",
                 i, sel_t[i], ins_t[i], Imm_Ext, exp_t[i]);
      end
    end
  endtask

  task automatic test_random();
    logic [31:0] ins;
    for (int sel = 0; sel < 5; sel++) begin
      for (int k = 0; k < 16; k++) begin
        ins = $urandom;
        drive(ins, 3'(sel));
        settle();
        vectors++;
        if (Imm_Ext !== ref_imm(ins, 3'(sel))) begin
          miscompares++;
          $display("FAIL random sel=%0d instr=%h: got %h want %h",
                   sel, ins, Imm_Ext, ref_imm(ins, 3'(sel)));
        end
      end
    end
    vectors++;
    if (Imm_Sel_Err !== 1'b0) begin
      miscompares++;
      $display("FAIL random_err: got %b want 0", Imm_Sel_Err);
    end
  endtask

  // Toggling bits a format does not reference must not change the result.
  task automatic test_unused_bits();
    logic [31:0] ins, mask, alt;
    for (int sel = 0; sel < 5; sel++) begin
      case (sel)
        0: mask = 32'h000F_FFFF;
        1: mask = 32'h01FF_F07F;
        2: mask = 32'h01FF_F07F;
        3: mask = 32'h0000_0FFF;
        default: mask = 32'h0000_007F;
      endcase
      ins = $urandom;
      alt = ins ^ (mask & $urandom);
      drive(alt, 3'(sel));
      settle();
      vectors++;
      if (Imm_Ext !== ref_imm(ins, 3'(sel))) begin
        miscompares++;
        $display("FAIL unused_bits sel=%0d instr=%h: got %h want %h",
                 sel, alt, Imm_Ext, ref_imm(ins, 3'(sel)));
      end
    end
  endtask

  task automatic test_sel_err();
    logic [31:0] ins;
    for (int code = 5; code < 8; code++) begin
      ins = $urandom;
      drive(ins, 3'(code));
      #1;
      vectors++;
      if (Imm_Sel_Err !== 1'b0) begin
        miscompares++;
        $display("FAIL err_early code=%0d: got %b want 0", code, Imm_Sel_Err);
      end
`ifndef IMM_EXT_REG_EN
      vectors++;
      if (Imm_Ext !== DEF_IMM) begin
        miscompares++;
        $display("FAIL default_imm_comb code=%0d: got %h want %h", code, Imm_Ext, DEF_IMM);
      end
`endif
      @(posedge CLK); #1;
      vectors++;
      if (Imm_Sel_Err !== 1'b1) begin
        miscompares++;
        $display("FAIL err_set code=%0d: got %b want 1", code, Imm_Sel_Err);
      end
      vectors++;
      if (Imm_Ext !== DEF_IMM) begin
        miscompares++;
        $display("FAIL default_imm code=%0d: got %h want %h", code, Imm_Ext, DEF_IMM);
      end
      for (int c = 0; c < 3; c++) begin
        drive($urandom, 3'd0);
        @(posedge CLK); #1;
        vectors++;
        if (Imm_Sel_Err !== 1'b1) begin
          miscompares++;
          $display("FAIL err_sticky code=%0d cyc=%0d: got %b want 1", code, c, Imm_Sel_Err);
        end
      end
      @(negedge CLK); RST = 1'b1;
      @(posedge CLK); #1;
      vectors++;
      if (Imm_Sel_Err !== 1'b0) begin
        miscompares++;
        $display("FAIL err_clear code=%0d: got %b want 0", code, Imm_Sel_Err);
      end
      @(negedge CLK); RST = 1'b0;
    end
    // Reset takes priority over a simultaneous unsupported select.
    drive($urandom, 3'd7);
    RST = 1'b1;
    @(posedge CLK); #1;
    vectors++;
    if (Imm_Sel_Err !== 1'b0) begin
      miscompares++;
      $display("FAIL err_reset_priority: got %b want 0", Imm_Sel_Err);
    end
    @(negedge CLK); RST = 1'b0; Imm_Type_Sel = 3'd0;
  endtask

  task automatic test_latency();
    logic [31:0] a, b;
    a = $urandom | 32'h8000_0000;
    b = $urandom & 32'h7FFF_FFFF;
`ifdef IMM_EXT_REG_EN
    drive(a, 3'd4);
    @(posedge CLK); #1;
    drive(b, 3'd4);
    #1;
    vectors++;
    if (Imm_Ext !== ref_imm(a, 3'd4)) begin
      miscompares++;
      $display("FAIL latency_hold: got %h want %h", Imm_Ext, ref_imm(a, 3'd4));
    end
    @(posedge CLK); #1;
    vectors++;
    if (Imm_Ext !== ref_imm(b, 3'd4)) begin
      miscompares++;
      $display("FAIL latency_one: got %h want %h", Imm_Ext, ref_imm(b, 3'd4));
    end
`else
    drive(a, 3'd2);
    #1;
    Instr = b;
    #1;
    vectors++;
    if (Imm_Ext !== ref_imm(b, 3'd2)) begin
      miscompares++;
      $display("FAIL latency_zero: got %h want %h", Imm_Ext, ref_imm(b, 3'd2));
    end
`endif
  endtask

  initial begin
    test_reset();
    test_directed();
    test_random();
    test_unused_bits();
    test_latency();
    test_sel_err();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
